// File: rtl/axi_wr_burst_engine.sv
// AXI write burst master: splits one descriptor into INCR bursts, tracks B responses.
// Optional stall counters are built when AXI_WR_PERF_CNT_EN is defined.
module axi_wr_burst_engine #(
    parameter int AXI_IDW        = 4,
    parameter int AXI_DATA_WID   = 256,
    parameter int AXI_LENW       = 8,
    parameter int MAX_OUTSTD     = 16,
    parameter int LEN_FIFO_DEPTH = 8
) (
    input  logic                      aclk,
    input  logic                      areset,
    input  logic [AXI_LENW-1:0]       cfg_max_len,
    input  logic [4:0]                cfg_outstd,
    input  logic                      cfg_split4k_en,
    input  logic [AXI_IDW-1:0]        cfg_awid,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [31:0]               cmd_addr,
    input  logic [31:0]               cmd_num_beats,
    input  logic                      src_valid,
    output logic                      src_ready,
    input  logic [AXI_DATA_WID-1:0]   src_data,
    input  logic [AXI_DATA_WID/8-1:0] src_strb,
    output logic                      o_awvalid,
    output logic [AXI_IDW-1:0]        o_awid,
    output logic [31:0]               o_awaddr,
    output logic [AXI_LENW-1:0]       o_awlen,
    output logic [2:0]                o_awsize,
    output logic [1:0]                o_awburst,
    input  logic                      i_awready,
    output logic                      o_wvalid,
    output logic [AXI_DATA_WID-1:0]   o_wdata,
    output logic [AXI_DATA_WID/8-1:0] o_wstrb,
    output logic                      o_wlast,
    input  logic                      i_wready,
    input  logic                      i_bvalid,
    input  logic [AXI_IDW-1:0]        i_bid,
    input  logic [1:0]                i_bresp,
    output logic                      o_bready,
    output logic                      busy,
    output logic                      done,
    output logic                      bresp_err,
    output logic [31:0]               perf_aw_stall,
    output logic [31:0]               perf_w_stall
);
    localparam int BYTES = AXI_DATA_WID / 8;
    localparam int OFS   = $clog2(BYTES);
    localparam int PW    = $clog2(LEN_FIFO_DEPTH);
    localparam int CW    = PW + 1;
    localparam int OW    = $clog2(MAX_OUTSTD + 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_AW, S_DRAIN} state_t;

    state_t              state;
    logic [31:0]         addr, remaining, eff_outstd;
    logic [AXI_LENW:0]   len_beats;
    logic [AXI_LENW-1:0] len_m1, beat_cnt;
    logic [OW-1:0]       outstd;
    logic [AXI_LENW-1:0] fifo_mem [LEN_FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       fifo_cnt;
    logic [32:0]         lim_max, lim_4k, len_calc;
    logic fifo_full, fifo_empty, cmd_hs, aw_hs, w_hs, pop, b_hs, b_dec;
    logic out_zero_next, fifo_zero_next;
    logic unused_ok;

    assign fifo_full  = (fifo_cnt == CW'(LEN_FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);
    assign cmd_hs     = cmd_valid & cmd_ready;
    assign aw_hs      = o_awvalid & i_awready;
    assign w_hs       = o_wvalid & i_wready;
    assign pop        = w_hs & o_wlast;
    assign b_hs       = i_bvalid & o_bready;
    assign b_dec      = b_hs & (outstd != '0);
    assign len_m1     = AXI_LENW'(len_beats - 1'b1);

    always_comb begin
        eff_outstd = 32'(cfg_outstd);
        if (cfg_outstd == 5'd0)
            eff_outstd = 32'd1;
        else if (32'(cfg_outstd) > 32'(MAX_OUTSTD))
            eff_outstd = 32'(MAX_OUTSTD);
    end

    // Burst length is the tightest of: beats left, max length, distance to 4 KB edge.
    always_comb begin
        lim_max  = 33'(cfg_max_len) + 33'd1;
        lim_4k   = cfg_split4k_en ? 33'((13'h1000 - {1'b0, addr[11:0]}) >> OFS) : {1'b1, 32'b0};
        len_calc = {1'b0, remaining};
        if (lim_max < len_calc) len_calc = lim_max;
        if (lim_4k  < len_calc) len_calc = lim_4k;
    end

    assign o_awvalid = (state == S_AW) && (32'(outstd) < eff_outstd) && !fifo_full;
    assign o_awaddr  = addr;
    assign o_awlen   = len_m1;
    assign o_awsize  = 3'(OFS);
    assign o_awburst = 2'b01;
    assign o_bready  = !areset;

    assign o_wvalid  = src_valid & !fifo_empty;
    assign src_ready = i_wready & !fifo_empty;
    assign o_wdata   = src_data;
    assign o_wstrb   = src_strb;
    assign o_wlast   = !fifo_empty && (beat_cnt == fifo_mem[rd_ptr]);

    // Completion may coincide with the final B / final pop.
    assign out_zero_next  = (outstd == '0) || ((outstd == OW'(1)) && b_dec);
    assign fifo_zero_next = fifo_empty || ((fifo_cnt == CW'(1)) && pop);

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= S_IDLE; addr <= '0; remaining <= '0; len_beats <= '0;
            o_awid <= '0; busy <= 1'b0; done <= 1'b0; cmd_ready <= 1'b0; bresp_err <= 1'b0;
        end else begin
            done <= 1'b0;
            if (b_hs && i_bresp != 2'b00) bresp_err <= 1'b1;
            case (state)
                S_IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_hs) begin
                        if (cmd_num_beats == 32'd0) begin
                            done <= 1'b1;
                        end else begin
                            addr      <= cmd_addr & ~32'(BYTES - 1);
                            remaining <= cmd_num_beats;
                            o_awid    <= cfg_awid;
                            bresp_err <= 1'b0;
                            busy      <= 1'b1;
                            cmd_ready <= 1'b0;
                            state     <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    len_beats <= len_calc[AXI_LENW:0];
                    state     <= S_AW;
                end
                S_AW: if (aw_hs) begin
                    addr      <= addr + (32'(len_beats) << OFS);
                    remaining <= remaining - 32'(len_beats);
                    state     <= (remaining != 32'(len_beats)) ? S_CALC : S_DRAIN;
                end
                default: if (out_zero_next && fifo_zero_next) begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            outstd <= '0;
        end else if (aw_hs && !b_dec) begin
            outstd <= outstd + OW'(1);
        end else if (!aw_hs && b_dec) begin
            outstd <= outstd - OW'(1);
        end
    end

    // Burst-length FIFO drives WLAST; W may only run ahead over bursts already issued.
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_ptr <= '0; rd_ptr <= '0; fifo_cnt <= '0; beat_cnt <= '0;
        end else begin
            if (aw_hs) begin
                fifo_mem[wr_ptr] <= len_m1;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            fifo_cnt <= fifo_cnt + CW'(aw_hs) - CW'(pop);
            if (w_hs) beat_cnt <= o_wlast ? '0 : beat_cnt + AXI_LENW'(1);
        end
    end

`ifdef AXI_WR_PERF_CNT_EN
    always_ff @(posedge aclk) begin
        if (areset || cmd_hs) begin
            perf_aw_stall <= '0;
            perf_w_stall  <= '0;
        end else begin
            if (o_awvalid && !i_awready && perf_aw_stall != '1) perf_aw_stall <= perf_aw_stall + 32'd1;
            if (o_wvalid && !i_wready && perf_w_stall != '1)    perf_w_stall  <= perf_w_stall + 32'd1;
        end
    end
`else
    assign perf_aw_stall = '0;
    assign perf_w_stall  = '0;
`endif

    assign unused_ok = ^{i_bid, len_calc[32:AXI_LENW+1]};
endmodule

// File: tb/tb_axi_wr_burst_engine.sv
// Directed bench for axi_wr_burst_engine with a small AXI slave responder.
module tb_axi_wr_burst_engine;
    localparam int IDW = 4, DW = 256, LW = 8;

    logic            aclk = 1'b0, areset;
    logic [LW-1:0]   cfg_max_len;
    logic [4:0]      cfg_outstd;
    logic            cfg_split4k_en;
    logic [IDW-1:0]  cfg_awid;
    logic            cmd_valid, cmd_ready;
    logic [31:0]     cmd_addr, cmd_num_beats;
    logic            src_valid, src_ready;
    logic [DW-1:0]   src_data;
    logic [DW/8-1:0] src_strb;
    logic            o_awvalid, i_awready;
    logic [IDW-1:0]  o_awid;
    logic [31:0]     o_awaddr;
    logic [LW-1:0]   o_awlen;
    logic [2:0]      o_awsize;
    logic [1:0]      o_awburst;
    logic            o_wvalid, o_wlast, i_wready;
    logic [DW-1:0]   o_wdata;
    logic [DW/8-1:0] o_wstrb;
    logic            i_bvalid, o_bready;
    logic [IDW-1:0]  i_bid;
    logic [1:0]      i_bresp;
    logic            busy, done, bresp_err;
    logic [31:0]     perf_aw_stall, perf_w_stall;

    axi_wr_burst_engine dut (
        .aclk(aclk), .areset(areset), .cfg_max_len(cfg_max_len), .cfg_outstd(cfg_outstd),
        .cfg_split4k_en(cfg_split4k_en), .cfg_awid(cfg_awid), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_num_beats(cmd_num_beats),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_strb(src_strb),
        .o_awvalid(o_awvalid), .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awlen(o_awlen),
        .o_awsize(o_awsize), .o_awburst(o_awburst), .i_awready(i_awready),
        .o_wvalid(o_wvalid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast),
        .i_wready(i_wready), .i_bvalid(i_bvalid), .i_bid(i_bid), .i_bresp(i_bresp),
        .o_bready(o_bready), .busy(busy), .done(done), .bresp_err(bresp_err),
        .perf_aw_stall(perf_aw_stall), .perf_w_stall(perf_w_stall)
    );

    always #5 aclk = ~aclk;

    int checks = 0, errors = 0;
    int cyc = 0, aw_cnt, w_cnt, wl_cnt, b_cnt, done_cnt, done_cyc, last_b_cyc, data_err, hdr_err, bad_b;
    logic [31:0] aw_addr_q[$];
    int          aw_len_q[$];
    bit          w_last_q[$];
    bit          b_auto, bresp_at_done;
    logic [31:0] w_seq;

    task automatic clr_mon();
        aw_cnt = 0; w_cnt = 0; wl_cnt = 0; b_cnt = 0; done_cnt = 0; data_err = 0; hdr_err = 0;
        done_cyc = -1; last_b_cyc = -3; bad_b = -1; bresp_at_done = 0;
        aw_addr_q.delete(); aw_len_q.delete(); w_last_q.delete();
    endtask

    // Observe handshakes 1ns after the inputs settle, then advance one clock.
    task automatic cycle();
        bit acc, w_hs;
        #1;
        acc  = cmd_valid && cmd_ready;
        w_hs = o_wvalid && i_wready;
        if (o_awvalid && i_awready) begin
            aw_addr_q.push_back(o_awaddr); aw_len_q.push_back(int'(o_awlen)); aw_cnt++;
            if (o_awid !== cfg_awid || o_awsize !== 3'd5 || o_awburst !== 2'b01) hdr_err++;
        end
        if (o_wvalid && (o_wdata !== src_data || o_wstrb !== src_strb)) data_err++;
        if (w_hs) begin w_last_q.push_back(o_wlast); w_cnt++; if (o_wlast) wl_cnt++; end
        if (i_bvalid && o_bready) begin b_cnt++; last_b_cyc = cyc; end
        if (done) begin done_cnt++; done_cyc = cyc; bresp_at_done = bresp_err; end
        @(posedge aclk); #1; cyc++;
        if (acc) cmd_valid = 1'b0;
        if (w_hs) begin w_seq++; src_data = {8{w_seq}}; src_strb = ~w_seq; end
        if (b_auto) begin
            i_bvalid = (wl_cnt > b_cnt);
            i_bresp  = (b_cnt == bad_b) ? 2'b10 : 2'b00;
        end
    endtask

    task automatic start_cmd(input logic [31:0] a, input logic [31:0] n);
        int k = 0;
        cmd_addr = a; cmd_num_beats = n; cmd_valid = 1'b1;
        while (cmd_valid && k < 50) begin cycle(); k++; end
        checks++;
        if (cmd_valid) begin
            errors++; $display("FAIL cmd_accept: not accepted, required within 50 cycles");
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin cycle(); k++; end
        checks++;
        if (done_cnt == 0) begin errors++; $display("FAIL done_timeout: no done within %0d cycles", budget); end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) cycle();
        checks++;
        if ({o_awvalid, o_wvalid, o_wlast, cmd_ready, busy, done, bresp_err, o_bready} !== 8'b0 ||
            perf_aw_stall !== 32'd0 || perf_w_stall !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: aw=%b w=%b last=%b crdy=%b busy=%b done=%b err=%b bready=%b required all 0",
                     o_awvalid, o_wvalid, o_wlast, cmd_ready, busy, done, bresp_err, o_bready);
        end
        areset = 1'b0;
        repeat (2) cycle();
        checks++;
        if (o_bready !== 1'b1 || cmd_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset: bready=%b cmd_ready=%b required 1 1", o_bready, cmd_ready);
        end
    endtask

    task automatic test_split4k();
        bit bad_last = 0;
        clr_mon(); cfg_max_len = 8'd15; cfg_split4k_en = 1'b1;
        start_cmd(32'h0000_0FC5, 32'd10);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL split_busy: busy=%b required 1", busy); end
        wait_done(300);
        checks++;
        if (aw_cnt != 2 || aw_addr_q[0] !== 32'h0FC0 || aw_len_q[0] != 1 ||
            aw_addr_q[1] !== 32'h1000 || aw_len_q[1] != 7) begin
            errors++;
            $display("FAIL split_aw: cnt=%0d a0=%h l0=%0d a1=%h l1=%0d required 2 fc0 1 1000 7",
                     aw_cnt, aw_addr_q[0], aw_len_q[0], aw_addr_q[1], aw_len_q[1]);
        end
        for (int i = 0; i < w_last_q.size(); i++) if (w_last_q[i] != (i == 1 || i == 9)) bad_last = 1;
        checks++;
        if (w_cnt != 10 || bad_last) begin
            errors++; $display("FAIL split_wlast: beats=%0d pattern_bad=%0d required 10 0", w_cnt, bad_last);
        end
        checks++;
        if (done_cyc != last_b_cyc + 1) begin
            errors++; $display("FAIL split_done_lat: done@%0d lastB@%0d required done=lastB+1", done_cyc, last_b_cyc);
        end
        checks++;
        if (hdr_err != 0 || data_err != 0) begin
            errors++; $display("FAIL split_payload: hdr_err=%0d data_err=%0d required 0 0", hdr_err, data_err);
        end
        cycle();
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL split_done_pulse: pulses=%0d busy=%b required 1 0", done_cnt, busy);
        end
    endtask

    task automatic test_max_len();
        clr_mon(); cfg_max_len = 8'd3;
        start_cmd(32'h0, 32'd9); wait_done(300);
        checks++;
        if (aw_cnt != 3 || aw_len_q[0] != 3 || aw_len_q[1] != 3 || aw_len_q[2] != 0 ||
            aw_addr_q[0] !== 32'h000 || aw_addr_q[1] !== 32'h080 || aw_addr_q[2] !== 32'h100 ||
            w_cnt != 9 || wl_cnt != 3) begin
            errors++;
            $display("FAIL maxlen_aw: cnt=%0d lens=%0d,%0d,%0d addrs=%h,%h,%h beats=%0d required 3 3,3,0 0,80,100 9",
                     aw_cnt, aw_len_q[0], aw_len_q[1], aw_len_q[2], aw_addr_q[0], aw_addr_q[1], aw_addr_q[2], w_cnt);
        end
        clr_mon(); cfg_max_len = 8'd15; cfg_split4k_en = 1'b0;
        start_cmd(32'h0000_0FE0, 32'd4); wait_done(300);
        checks++;
        if (aw_cnt != 1 || aw_addr_q[0] !== 32'h0FE0 || aw_len_q[0] != 3) begin
            errors++; $display("FAIL no_split_cross: cnt=%0d addr=%h len=%0d required 1 fe0 3", aw_cnt, aw_addr_q[0], aw_len_q[0]);
        end
        clr_mon(); cfg_max_len = 8'd0;
        start_cmd(32'hFFFF_FFE0, 32'd2); wait_done(300);
        checks++;
        if (aw_cnt != 2 || aw_addr_q[0] !== 32'hFFFF_FFE0 || aw_addr_q[1] !== 32'h0) begin
            errors++; $display("FAIL addr_wrap: cnt=%0d a0=%h a1=%h required 2 ffffffe0 0", aw_cnt, aw_addr_q[0], aw_addr_q[1]);
        end
        cfg_split4k_en = 1'b1;
    endtask

    task automatic test_outstd();
        clr_mon(); cfg_outstd = 5'd2; cfg_max_len = 8'd0; b_auto = 0; i_bvalid = 1'b0;
        start_cmd(32'h0, 32'd5);
        repeat (30) cycle();
        checks++;
        if (aw_cnt != 2 || o_awvalid !== 1'b0) begin
            errors++; $display("FAIL outstd_cap: aw=%0d awvalid=%b required 2 0", aw_cnt, o_awvalid);
        end
        i_bvalid = 1'b1; i_bresp = 2'b00; cycle(); i_bvalid = 1'b0;
        repeat (20) cycle();
        checks++;
        if (aw_cnt != 3 || b_cnt != 1 || o_awvalid !== 1'b0) begin
            errors++; $display("FAIL outstd_release: aw=%0d b=%0d awvalid=%b required 3 1 0", aw_cnt, b_cnt, o_awvalid);
        end
        b_auto = 1; wait_done(300);
        checks++;
        if (aw_cnt != 5 || b_cnt != 5) begin
            errors++; $display("FAIL outstd_finish: aw=%0d b=%0d required 5 5", aw_cnt, b_cnt);
        end
    endtask

    task automatic test_outstd_zero();
        clr_mon(); cfg_outstd = 5'd0; cfg_max_len = 8'd0; b_auto = 0;
        start_cmd(32'h0, 32'd2);
        repeat (20) cycle();
        checks++;
        if (aw_cnt != 1 || o_awvalid !== 1'b0) begin
            errors++; $display("FAIL outstd_zero: aw=%0d awvalid=%b required 1 0", aw_cnt, o_awvalid);
        end
        b_auto = 1; wait_done(300);
        checks++;
        if (aw_cnt != 2) begin errors++; $display("FAIL outstd_zero_finish: aw=%0d required 2", aw_cnt); end
    endtask

    task automatic test_same_cycle();
        int k = 0;
        clr_mon(); cfg_outstd = 5'd2; cfg_max_len = 8'd0; b_auto = 0; i_awready = 1'b0;
        start_cmd(32'h0, 32'd4);
        i_awready = 1'b1;
        while (aw_cnt < 1 && k < 50) begin cycle(); k++; end
        i_awready = 1'b0;
        repeat (4) cycle();
        checks++;
        if (o_awvalid !== 1'b1) begin errors++; $display("FAIL same_pre: awvalid=%b required 1", o_awvalid); end
        i_bvalid = 1'b1; i_awready = 1'b1; cycle(); i_bvalid = 1'b0; i_awready = 1'b0;
        checks++;
        if (aw_cnt != 2 || b_cnt != 1) begin
            errors++; $display("FAIL same_hs: aw=%0d b=%0d required 2 1", aw_cnt, b_cnt);
        end
        repeat (4) cycle();
        checks++;
        if (o_awvalid !== 1'b1) begin errors++; $display("FAIL same_outstd1: awvalid=%b required 1", o_awvalid); end
        i_awready = 1'b1; k = 0;
        while (aw_cnt < 3 && k < 50) begin cycle(); k++; end
        i_awready = 1'b0;
        repeat (4) cycle();
        checks++;
        if (o_awvalid !== 1'b0) begin errors++; $display("FAIL same_outstd2: awvalid=%b required 0", o_awvalid); end
        i_awready = 1'b1; b_auto = 1; wait_done(300);
        checks++;
        if (aw_cnt != 4) begin errors++; $display("FAIL same_finish: aw=%0d required 4", aw_cnt); end
        cfg_outstd = 5'd16;
    endtask

    task automatic test_bresp();
        clr_mon(); cfg_max_len = 8'd0; bad_b = 1;
        start_cmd(32'h100, 32'd3); wait_done(300);
        checks++;
        if (b_cnt != 3 || bresp_at_done !== 1'b1) begin
            errors++; $display("FAIL bresp_done: b=%0d err_at_done=%b required 3 1", b_cnt, bresp_at_done);
        end
        cycle();
        checks++;
        if (bresp_err !== 1'b1) begin errors++; $display("FAIL bresp_sticky: err=%b required 1", bresp_err); end
        clr_mon();
        start_cmd(32'h200, 32'd1);
        checks++;
        if (bresp_err !== 1'b0) begin errors++; $display("FAIL bresp_clear: err=%b required 0", bresp_err); end
        wait_done(300);
    endtask

    task automatic test_zero_beats();
        clr_mon();
        start_cmd(32'h300, 32'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_done: done=%b busy=%b required 1 0", done, busy);
        end
        repeat (5) cycle();
        checks++;
        if (done_cnt != 1 || aw_cnt != 0 || w_cnt != 0 || o_awvalid !== 1'b0) begin
            errors++; $display("FAIL zero_traffic: pulses=%0d aw=%0d w=%0d required 1 0 0", done_cnt, aw_cnt, w_cnt);
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        logic [31:0] exp_w;
`ifdef AXI_WR_PERF_CNT_EN
        exp_w = 32'd5;
`else
        exp_w = 32'd0;
`endif
        clr_mon(); cfg_max_len = 8'd7; i_wready = 1'b0;
        start_cmd(32'h2000, 32'd16);
        while (aw_cnt < 1 && k < 50) begin cycle(); k++; end
        repeat (5) cycle();
        checks++;
        if (perf_w_stall !== exp_w || perf_aw_stall !== 32'd0) begin
            errors++; $display("FAIL perf_stall: w=%0d aw=%0d required %0d 0", perf_w_stall, perf_aw_stall, exp_w);
        end
        i_wready = 1'b1;
        repeat (3) cycle();
        areset = 1'b1; cycle();
        checks++;
        if ({o_awvalid, o_wvalid, o_wlast, cmd_ready, busy, done, bresp_err, o_bready} !== 8'b0 ||
            perf_w_stall !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: aw=%b w=%b last=%b crdy=%b busy=%b done=%b err=%b bready=%b pw=%0d required all 0",
                     o_awvalid, o_wvalid, o_wlast, cmd_ready, busy, done, bresp_err, o_bready, perf_w_stall);
        end
        areset = 1'b0; i_bvalid = 1'b0; clr_mon(); cycle();
        start_cmd(32'h3000, 32'd4); wait_done(300);
        checks++;
        if (aw_cnt != 1 || aw_addr_q[0] !== 32'h3000 || aw_len_q[0] != 3 || w_cnt != 4 || wl_cnt != 1) begin
            errors++;
            $display("FAIL after_reset: aw=%0d addr=%h len=%0d w=%0d last=%0d required 1 3000 3 4 1",
                     aw_cnt, aw_addr_q[0], aw_len_q[0], w_cnt, wl_cnt);
        end
    endtask

    initial begin
        areset = 1'b1; cfg_max_len = 8'd15; cfg_outstd = 5'd16; cfg_split4k_en = 1'b1; cfg_awid = 4'hA;
        cmd_valid = 1'b0; cmd_addr = '0; cmd_num_beats = '0; src_valid = 1'b1; w_seq = 32'd0;
        src_data = '0; src_strb = '1; i_awready = 1'b1; i_wready = 1'b1; i_bvalid = 1'b0;
        i_bid = '0; i_bresp = 2'b00; b_auto = 1;
        clr_mon();
        test_reset();
        test_split4k();
        test_max_len();
        test_outstd();
        test_outstd_zero();
        test_same_cycle();
        test_bresp();
        test_zero_beats();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
